// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : shift_sequencer
//  Purpose  : Multi-cycle shift controller. Accepts one operand, a direction
//             and a shift amount over a valid/ready handshake, then shifts
//             the operand iteratively by at most STEP bits per clock through
//             one fixed-width shift stage. Results are returned over a
//             valid/ready handshake, and backpressure is supported.
//  Ports    : clk         clock, rising edge
//             rst         synchronous reset, active-low
//             up_valid    request valid
//             up_ready    request can be accepted (IDLE and not in reset)
//             up_data     operand [W-1:0]
//             up_amt      unsigned shift amount [AW-1:0], clamped to W
//             up_dir      0 = left, 1 = right
//             up_arith    1 = arithmetic right (sign fill)
//             down_valid  result valid
//             down_ready  consumer accepts result
//             down_data   shifted result [W-1:0]
//             busy        state != IDLE
//  Revision : 1.0  initial release
// ============================================================================
module shift_sequencer #(
   parameter int W    = 8,
   parameter int STEP = 3,
   localparam int AW  = $clog2(W + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          up_valid,
   output logic          up_ready,
   input  logic [W-1:0]  up_data,
   input  logic [AW-1:0] up_amt,
   input  logic          up_dir,
   input  logic          up_arith,
   output logic          down_valid,
   input  logic          down_ready,
   output logic [W-1:0]  down_data,
   output logic          busy
);

   localparam logic [AW-1:0] C_W_AMT    = AW'(W);
   localparam logic [AW-1:0] C_STEP_AMT = AW'(STEP);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t        state_q;
   logic [W-1:0]  data_q;
   logic [AW-1:0] rem_q;
   logic          dir_q;
   logic          fill_q;
   logic          down_valid_q;
   logic          busy_q;

   logic [AW-1:0] amt_clamp;
   logic [AW-1:0] step_k;
   logic [W-1:0]  shl;
   logic [W-1:0]  shr;
   logic [W-1:0]  data_d;
   logic [AW-1:0] rem_d;

   // Amounts beyond W behave exactly like W: every bit is replaced by fill.
   assign amt_clamp = (up_amt > C_W_AMT) ? C_W_AMT : up_amt;

   // Distance applied this cycle, never more than STEP.
   assign step_k = (rem_q < C_STEP_AMT) ? rem_q : C_STEP_AMT;

   // Single shift stage. The right-shift fill is produced by inverting a
   // shifted all-ones mask so that only the vacated top bits take fill_q.
   assign shl    = data_q << step_k;
   assign shr    = (data_q >> step_k) | ({W{fill_q}} & ~({W{1'b1}} >> step_k));
   assign data_d = dir_q ? shr : shl;
   assign rem_d  = rem_q - step_k;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         data_q       <= '0;
         rem_q        <= '0;
         dir_q        <= 1'b0;
         fill_q       <= 1'b0;
         down_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (up_valid) begin
                  data_q  <= up_data;
                  dir_q   <= up_dir;
                  fill_q  <= up_arith & up_dir & up_data[W-1];
                  rem_q   <= amt_clamp;
                  busy_q  <= 1'b1;
                  state_q <= (amt_clamp != '0) ? S_SHIFT : S_DONE;
               end
            end
            S_SHIFT: begin
               data_q <= data_d;
               rem_q  <= rem_d;
               if (rem_d == '0) begin
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               // down_valid is raised one cycle after entering DONE; data_q
               // is frozen here so the result is stable under backpressure.
               if (down_valid_q && down_ready) begin
                  state_q      <= S_IDLE;
                  down_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
               end else begin
                  down_valid_q <= 1'b1;
               end
            end
            default: begin
               state_q      <= S_IDLE;
               down_valid_q <= 1'b0;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   assign up_ready   = (state_q == S_IDLE) && rst;
   assign down_valid = down_valid_q;
   assign down_data  = data_q;
   assign busy       = busy_q;

endmodule
`default_nettype wire
